eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, sets the number of AXI-stream frame sources sharing the Ethernet MAC TX port (legal 2..4).
REQ-002 Parameter STALL_LIMIT, default 1024, sets the consecutive mid-frame starvation cycles before the stall error is flagged.
REQ-003 clk  input  1  sole clock; all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ArbEnable  input  1  high permits new frame grants; low blocks new grants only.
REQ-006 s_tdata  input  NUM_REQ*32  source data, source i in bits [32i+31:32i].
REQ-007 s_tkeep  input  NUM_REQ*4  byte strobes per source.
REQ-008 s_tvalid / s_tlast  input  NUM_REQ each  per-source valid and end-of-frame.
REQ-009 s_tready  output  NUM_REQ  per-source ready.
REQ-010 m_tdata / m_tkeep / m_tvalid / m_tlast  output  32 / 4 / 1 / 1  stream to the MAC TX FIFO.
REQ-011 m_tready  input  1  MAC TX ready.
REQ-012 Grant  output  2  index of the source currently owning the port.
REQ-013 Busy  output  1  high while a frame is granted.
REQ-014 StallErr  output  1  sticky starvation flag.
REQ-015 FrameCount  output  NUM_REQ*16  per-source count of completed frames.

Function
REQ-016 State machine SHALL have states IDLE and BUSY.
- IDLE -> BUSY: ArbEnable=1 and any s_tvalid=1; Grant registered in that cycle.
- BUSY -> IDLE: the cycle after the granted source's tlast beat is accepted.
REQ-017 Arbitration SHALL be round-robin at frame granularity: search starts at (last grant + 1) mod NUM_REQ; the first requester with s_tvalid=1 wins.
REQ-018 Grant SHALL be held constant for the whole of a frame; other sources SHALL see s_tready=0 throughout.
REQ-019 In BUSY, s_tready[Grant] SHALL equal the skid-buffer input ready; a beat is accepted when s_tvalid[Grant] & s_tready[Grant].
REQ-020 In IDLE all s_tready bits SHALL be 0, giving exactly one bubble cycle between frames.
REQ-021 Output latency SHALL be 1 cycle from beat acceptance to m_tvalid when m_tready=1; data, keep and last SHALL pass unmodified and in order.
REQ-022 Output stage SHALL be a 2-entry skid buffer so that s_tready never depends combinationally on m_tready; full throughput of 1 beat/cycle is sustained while m_tready=1.
REQ-023 ArbEnable falling during BUSY SHALL NOT abort the frame; the arbiter finishes it and then stays in IDLE.
REQ-024 In BUSY, the stall counter SHALL increment on each cycle with s_tvalid[Grant]=0 and clear on any accepted beat; on reaching STALL_LIMIT, StallErr SHALL set and remain set until reset; the frame is not aborted.
REQ-025 FrameCount[i] SHALL increment by 1 on acceptance of source i's tlast and wrap from 16'hFFFF to 0.
REQ-026 Back-pressure on m_tready SHALL never drop or duplicate a beat, including when the tlast beat is in the skid buffer.

Reset
REQ-027 When reset is asserted: state=IDLE, Grant=NUM_REQ-1 (so source 0 wins first), Busy=0, s_tready=0, m_tvalid=0, skid buffer empty, stall counter=0, StallErr=0, all FrameCount=0.
REQ-028 Reset asserted mid-frame SHALL discard any partial frame in flight; downstream recovery of the truncated frame is owned by the MAC FIFO's bad-frame handling.

Structure
REQ-029 The state enum and the 32-bit data / 4-bit keep width constants SHALL live in the shared cvw package.
REQ-030 The skid buffer SHALL be one sub-module, axis_skid, with 32+4+1 bit payload; the arbiter FSM, counters and mux SHALL live in eth_tx_arb.

Verification
REQ-031 Src0 sends a 5-beat frame, src1 idle, m_tready=1 -> m_tvalid high for 5 consecutive cycles beginning 1 cycle after the first accept; FrameCount[0]=1.
REQ-032 Src0 and src1 both hold frames continuously -> grants alternate 0,1,0,1; no interleaving of beats within a frame.
REQ-033 m_tready toggles 1,0,0,1 during a 4-beat frame carrying data 0x11111111..0x44444444 -> output order is exact with no loss or duplication.
REQ-034 Src1 goes idle for STALL_LIMIT=8 cycles mid-frame -> StallErr rises on the 8th cycle, stays high; frame completes when src1 resumes.
REQ-035 ArbEnable drops on beat 2 of a 4-beat frame -> frame completes; the pending src0 frame is not granted until ArbEnable returns high.
REQ-036 Reset pulsed mid-frame -> all outputs return to REQ-027 values asynchronously; the next grant goes to src0.

Source files
------------

// File: rtl/cvw_pkg.sv
// Shared stream widths, beat payload and arbiter state encoding for the
// Ethernet TX arbitration slice.
package cvw_pkg;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry AXI-stream skid buffer: in_ready is a pure register output, so the
// upstream handshake never sees out_ready combinationally.
module axis_skid
  import cvw_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t skid_beat;
  logic  skid_valid;
  logic  in_fire;
  logic  out_load;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & ~skid_valid;
  assign out_load = ~out_valid | out_ready;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: payload registers are deliberately not reset; the valid flags alone
  // define emptiness, and leaving wide datapath regs unreset saves reset fanout.
  always_ff @(posedge clk) begin
    if (out_load) begin
      if (skid_valid) begin
        out_beat <= skid_beat;
      end else if (in_fire) begin
        out_beat <= in_beat;
      end
    end else if (in_fire) begin
      skid_beat <= in_beat;
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter merging NUM_REQ AXI-stream sources onto
// one MAC TX stream, with starvation detection and per-source frame counters.
module eth_tx_arb
  import cvw_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ArbEnable,
  input  logic [NUM_REQ*DATA_W-1:0] s_tdata,
  input  logic [NUM_REQ*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_REQ-1:0]        s_tvalid,
  input  logic [NUM_REQ-1:0]        s_tlast,
  output logic [NUM_REQ-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [1:0]                Grant,
  output logic                      Busy,
  output logic                      StallErr,
  output logic [NUM_REQ*16-1:0]     FrameCount
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  arb_state_e                 state;
  logic [1:0]                 grant;
  logic [1:0]                 next_grant;
  logic                       found;
  logic [CNT_W-1:0]           stall_cnt;
  logic                       stall_err;
  logic [NUM_REQ-1:0][15:0]   frame_cnt;
  beat_t                      sel_beat;
  beat_t                      out_beat;
  logic                       sel_valid;
  logic                       skid_ready;
  logic                       accept;

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 2'(i)) begin
        sel_valid     = s_tvalid[i];
        sel_beat.data = s_tdata[i*DATA_W +: DATA_W];
        sel_beat.keep = s_tkeep[i*KEEP_W +: KEEP_W];
        sel_beat.last = s_tlast[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      s_tready[i] = (state == BUSY) && (grant == 2'(i)) && skid_ready;
    end
  end

  assign accept = (state == BUSY) & sel_valid & skid_ready;

  // Search begins one past the previous owner so each source gets a turn.
  always_comb begin
    next_grant = grant;
    found      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && s_tvalid[j] && (((int'(grant) + k) % NUM_REQ) == j)) begin
          found      = 1'b1;
          next_grant = 2'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'(NUM_REQ - 1);
      stall_cnt <= '0;
      stall_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (ArbEnable && (|s_tvalid)) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            stall_cnt <= '0;
            if (sel_beat.last) begin
              state <= IDLE;
              for (int i = 0; i < NUM_REQ; i++) begin
                if (grant == 2'(i)) frame_cnt[i] <= frame_cnt[i] + 16'd1;
              end
            end
          end else if (!sel_valid && (stall_cnt != CNT_W'(STALL_LIMIT))) begin
            // Starvation is flagged but never aborts the frame.
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CNT_W'(STALL_LIMIT - 1)) stall_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_beat  (sel_beat),
    .in_valid (accept),
    .in_ready (skid_ready),
    .out_beat (out_beat),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

  assign m_tdata    = out_beat.data;
  assign m_tkeep    = out_beat.keep;
  assign m_tlast    = out_beat.last;
  assign Grant      = grant;
  assign Busy       = (state == BUSY);
  assign StallErr   = stall_err;
  assign FrameCount = frame_cnt;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: reset, single frame, round-robin, back-pressure,
// starvation, ArbEnable gating and mid-frame reset.
module tb_eth_tx_arb;

  localparam int NUM_REQ     = 2;
  localparam int STALL_LIMIT = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  ArbEnable = 1'b0;
  logic [NUM_REQ*32-1:0] s_tdata;
  logic [NUM_REQ*4-1:0]  s_tkeep;
  logic [NUM_REQ-1:0]    s_tvalid;
  logic [NUM_REQ-1:0]    s_tlast;
  logic [NUM_REQ-1:0]    s_tready;
  logic [31:0]           m_tdata;
  logic [3:0]            m_tkeep;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready = 1'b1;
  logic [1:0]            Grant;
  logic                  Busy;
  logic                  StallErr;
  logic [NUM_REQ*16-1:0] FrameCount;

  logic [31:0] dat [NUM_REQ];
  logic [3:0]  kp  [NUM_REQ];
  logic        vld [NUM_REQ];
  logic        lst [NUM_REQ];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [36:0] out_q[$];
  int          mv_cyc_q[$];
  int          acc_cyc_q[$];
  int          frame_src_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      s_tdata[i*32 +: 32] = dat[i];
      s_tkeep[i*4 +: 4]   = kp[i];
      s_tvalid[i]         = vld[i];
      s_tlast[i]          = lst[i];
    end
  end

  eth_tx_arb #(.NUM_REQ(NUM_REQ), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .reset(reset), .ArbEnable(ArbEnable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready), .Grant(Grant), .Busy(Busy),
    .StallErr(StallErr), .FrameCount(FrameCount)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observe both handshakes on the falling edge, where all signals are settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tkeep, m_tdata});
        mv_cyc_q.push_back(cyc);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          acc_cyc_q.push_back(cyc);
          if (s_tlast[i]) frame_src_q.push_back(i);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [36:0] exp_beat(input logic [31:0] base, input logic [31:0] step,
                                           input int b, input int n);
    logic last;
    last = (b == n - 1);
    return {last, last ? 4'h7 : 4'hF, base + 32'(b) * step};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    out_q.delete();
    mv_cyc_q.delete();
    acc_cyc_q.delete();
    frame_src_q.delete();
  endtask

  task automatic send_beats(input int src, input int first, input int cnt, input int total,
                            input logic [31:0] base, input logic [31:0] step, output bit ok);
    int          b;
    int          guard;
    bit          hs;
    logic [36:0] w;
    b = first;
    guard = 0;
    w = exp_beat(base, step, b, total);
    dat[src] = w[31:0]; kp[src] = w[35:32]; lst[src] = w[36]; vld[src] = 1'b1;
    while (b < first + cnt && guard < 300) begin
      @(negedge clk);
      hs = s_tready[src];
      tick();
      guard++;
      if (hs) begin
        b++;
        if (b < first + cnt) begin
          w = exp_beat(base, step, b, total);
          dat[src] = w[31:0]; kp[src] = w[35:32]; lst[src] = w[36];
        end else begin
          vld[src] = 1'b0; lst[src] = 1'b0;
        end
      end
    end
    vld[src] = 1'b0;
    ok = (b == first + cnt);
  endtask

  task automatic send_frame(input int src, input int n, input logic [31:0] base,
                            input logic [31:0] step, output bit ok);
    send_beats(src, 0, n, n, base, step, ok);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      dat[i] = '0; kp[i] = '0; vld[i] = 1'b0; lst[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++; if (Grant !== 2'd1) begin n_bad++; $display("FAIL reset_grant: got %0d want 1", Grant); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (s_tready !== 2'b00) begin n_bad++; $display("FAIL reset_tready: got %b want 00", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (StallErr !== 1'b0) begin n_bad++; $display("FAIL reset_stallerr: got %b want 0", StallErr); end
    n_cmp++; if (FrameCount !== 32'h0) begin n_bad++; $display("FAIL reset_framecount: got %h want 0", FrameCount); end
    reset = 1'b0;
    ArbEnable = 1'b1;
    m_tready = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_queues();
    send_frame(0, 5, 32'hA000_0000, 32'h1, ok);
    repeat (4) tick();
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", ok); end
    n_cmp++; if (out_q.size() != 5) begin n_bad++; $display("FAIL single_count: got %0d want 5", out_q.size()); end
    for (int b = 0; b < 5 && b < out_q.size(); b++) begin
      n_cmp++;
      if (out_q[b] !== exp_beat(32'hA000_0000, 32'h1, b, 5)) begin
        n_bad++; $display("FAIL single_beat%0d: got %h want %h", b, out_q[b], exp_beat(32'hA000_0000, 32'h1, b, 5));
      end
    end
    if (mv_cyc_q.size() == 5 && acc_cyc_q.size() == 5) begin
      n_cmp++; if (mv_cyc_q[0] != acc_cyc_q[0] + 1) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", mv_cyc_q[0], acc_cyc_q[0] + 1); end
      n_cmp++; if (mv_cyc_q[4] - mv_cyc_q[0] != 4) begin n_bad++; $display("FAIL single_contiguous: got span %0d want 4", mv_cyc_q[4] - mv_cyc_q[0]); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL single_timing: got %0d/%0d samples want 5/5", mv_cyc_q.size(), acc_cyc_q.size());
    end
    n_cmp++; if (FrameCount[15:0] !== 16'd1) begin n_bad++; $display("FAIL single_fc0: got %0d want 1", FrameCount[15:0]); end
  endtask

  task automatic test_round_robin();
    bit          ok0 [3];
    bit          ok1 [3];
    int          src;
    int          f;
    logic [31:0] base;
    clear_queues();
    fork
      begin
        for (int k = 0; k < 3; k++) send_frame(0, 3, 32'hB000_0000 | (32'(k) << 8), 32'h1, ok0[k]);
      end
      begin
        for (int k = 0; k < 3; k++) send_frame(1, 3, 32'hB001_0000 | (32'(k) << 8), 32'h1, ok1[k]);
      end
    join
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (!(ok0[k] && ok1[k])) begin n_bad++; $display("FAIL rr_done%0d: got %b%b want 11", k, ok0[k], ok1[k]); end
    end
    // Source 0 owned the port last, so source 1 is first in line.
    n_cmp++; if (frame_src_q.size() != 6) begin n_bad++; $display("FAIL rr_frames: got %0d want 6", frame_src_q.size()); end
    for (int k = 0; k < 6 && k < frame_src_q.size(); k++) begin
      src = (k % 2 == 0) ? 1 : 0;
      n_cmp++; if (frame_src_q[k] != src) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, frame_src_q[k], src); end
    end
    n_cmp++; if (out_q.size() != 18) begin n_bad++; $display("FAIL rr_beats: got %0d want 18", out_q.size()); end
    for (int k = 0; k < 18 && k < out_q.size(); k++) begin
      src  = ((k / 3) % 2 == 0) ? 1 : 0;
      f    = k / 6;
      base = 32'hB000_0000 | (32'(src) << 16) | (32'(f) << 8);
      n_cmp++;
      if (out_q[k] !== exp_beat(base, 32'h1, k % 3, 3)) begin
        n_bad++; $display("FAIL rr_beat%0d: got %h want %h", k, out_q[k], exp_beat(base, 32'h1, k % 3, 3));
      end
    end
    n_cmp++; if (FrameCount !== {16'd3, 16'd4}) begin n_bad++; $display("FAIL rr_fc: got %h want 00030004", FrameCount); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int g;
    int pat [8] = '{1, 0, 0, 1, 0, 0, 1, 1};
    clear_queues();
    fork
      send_frame(0, 4, 32'h1111_1111, 32'h1111_1111, ok);
      begin
        g = 0;
        while (!Busy && g < 50) begin tick(); g++; end
        for (int p = 0; p < 8; p++) begin
          m_tready = pat[p][0];
          tick();
        end
        m_tready = 1'b1;
      end
    join
    repeat (6) tick();
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", ok); end
    n_cmp++; if (out_q.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", out_q.size()); end
    for (int b = 0; b < 4 && b < out_q.size(); b++) begin
      n_cmp++;
      if (out_q[b] !== exp_beat(32'h1111_1111, 32'h1111_1111, b, 4)) begin
        n_bad++; $display("FAIL bp_beat%0d: got %h want %h", b, out_q[b], exp_beat(32'h1111_1111, 32'h1111_1111, b, 4));
      end
    end
    n_cmp++; if (FrameCount[15:0] !== 16'd5) begin n_bad++; $display("FAIL bp_fc0: got %0d want 5", FrameCount[15:0]); end
  endtask

  task automatic test_stall();
    bit ok;
    bit ok2;
    clear_queues();
    send_beats(1, 0, 2, 4, 32'h5000_0000, 32'h1, ok);
    repeat (STALL_LIMIT - 1) tick();
    n_cmp++; if (StallErr !== 1'b0) begin n_bad++; $display("FAIL stall_early: got %b want 0", StallErr); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", Busy); end
    tick();
    n_cmp++; if (StallErr !== 1'b1) begin n_bad++; $display("FAIL stall_rise: got %b want 1", StallErr); end
    send_beats(1, 2, 2, 4, 32'h5000_0000, 32'h1, ok2);
    repeat (4) tick();
    n_cmp++; if (!(ok && ok2)) begin n_bad++; $display("FAIL stall_done: got %b%b want 11", ok, ok2); end
    n_cmp++; if (StallErr !== 1'b1) begin n_bad++; $display("FAIL stall_sticky: got %b want 1", StallErr); end
    n_cmp++; if (FrameCount[31:16] !== 16'd4) begin n_bad++; $display("FAIL stall_fc1: got %0d want 4", FrameCount[31:16]); end
    n_cmp++; if (out_q.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", out_q.size()); end
    for (int b = 0; b < 4 && b < out_q.size(); b++) begin
      n_cmp++;
      if (out_q[b] !== exp_beat(32'h5000_0000, 32'h1, b, 4)) begin
        n_bad++; $display("FAIL stall_beat%0d: got %h want %h", b, out_q[b], exp_beat(32'h5000_0000, 32'h1, b, 4));
      end
    end
  endtask

  task automatic test_arb_enable();
    bit          ok;
    bit          ok2;
    bit          ok3;
    logic [36:0] w;
    clear_queues();
    send_beats(1, 0, 2, 4, 32'h6000_0000, 32'h1, ok);
    ArbEnable = 1'b0;
    w = exp_beat(32'h7000_0000, 32'h1, 0, 2);
    dat[0] = w[31:0]; kp[0] = w[35:32]; lst[0] = w[36]; vld[0] = 1'b1;
    send_beats(1, 2, 2, 4, 32'h6000_0000, 32'h1, ok2);
    repeat (3) tick();
    n_cmp++; if (!(ok && ok2)) begin n_bad++; $display("FAIL en_frame_done: got %b%b want 11", ok, ok2); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL en_blocked_busy: got %b want 0", Busy); end
    n_cmp++; if (s_tready !== 2'b00) begin n_bad++; $display("FAIL en_blocked_tready: got %b want 00", s_tready); end
    n_cmp++; if (frame_src_q.size() != 1) begin n_bad++; $display("FAIL en_frames: got %0d want 1", frame_src_q.size()); end
    n_cmp++; if (FrameCount !== {16'd5, 16'd5}) begin n_bad++; $display("FAIL en_fc_mid: got %h want 00050005", FrameCount); end
    ArbEnable = 1'b1;
    send_frame(0, 2, 32'h7000_0000, 32'h1, ok3);
    repeat (4) tick();
    n_cmp++; if (ok3 !== 1'b1) begin n_bad++; $display("FAIL en_resume: got %b want 1", ok3); end
    n_cmp++; if (FrameCount !== {16'd5, 16'd6}) begin n_bad++; $display("FAIL en_fc_end: got %h want 00050006", FrameCount); end
    n_cmp++; if (out_q.size() != 6) begin n_bad++; $display("FAIL en_count: got %0d want 6", out_q.size()); end
    for (int b = 0; b < 6 && b < out_q.size(); b++) begin
      w = (b < 4) ? exp_beat(32'h6000_0000, 32'h1, b, 4) : exp_beat(32'h7000_0000, 32'h1, b - 4, 2);
      n_cmp++; if (out_q[b] !== w) begin n_bad++; $display("FAIL en_beat%0d: got %h want %h", b, out_q[b], w); end
    end
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [36:0] w;
    send_beats(1, 0, 2, 4, 32'h8000_0000, 32'h1, ok);
    w = exp_beat(32'h8000_0000, 32'h1, 2, 4);
    dat[1] = w[31:0]; kp[1] = w[35:32]; lst[1] = w[36]; vld[1] = 1'b1;
    w = exp_beat(32'h9000_0000, 32'h1, 0, 2);
    dat[0] = w[31:0]; kp[0] = w[35:32]; lst[0] = w[36]; vld[0] = 1'b1;
    n_cmp++; if (!(ok && Busy && Grant == 2'd1)) begin n_bad++; $display("FAIL rst_pre: got ok=%b busy=%b grant=%0d want 1 1 1", ok, Busy, Grant); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", Busy); end
    n_cmp++; if (Grant !== 2'd1) begin n_bad++; $display("FAIL rst_grant: got %0d want 1", Grant); end
    n_cmp++; if (s_tready !== 2'b00) begin n_bad++; $display("FAIL rst_tready: got %b want 00", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (StallErr !== 1'b0) begin n_bad++; $display("FAIL rst_stallerr: got %b want 0", StallErr); end
    n_cmp++; if (FrameCount !== 32'h0) begin n_bad++; $display("FAIL rst_fc: got %h want 0", FrameCount); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (Grant !== 2'd0) begin n_bad++; $display("FAIL rst_next_grant: got %0d want 0", Grant); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL rst_next_busy: got %b want 1", Busy); end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_arb_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
